// File: rtl/interboard_tx_if.sv
// Parallel message link between the game controller, the transmit stage and
// the peer board. The transmit stage takes the master view; the controller
// and peer-board side takes the slave view.
interface interboard_tx_if;
   logic       ctrl_en;
   logic [2:0] ctrl_msg_type;
   logic [4:0] ctrl_number;
   logic       inter_ready;
   logic       tx_request;
   logic [2:0] tx_msg_type;
   logic [4:0] tx_number;
   logic       rx_ack;

   modport master (
      input  ctrl_en,
      input  ctrl_msg_type,
      input  ctrl_number,
      input  rx_ack,
      output inter_ready,
      output tx_request,
      output tx_msg_type,
      output tx_number
   );

   modport slave (
      output ctrl_en,
      output ctrl_msg_type,
      output ctrl_number,
      output rx_ack,
      input  inter_ready,
      input  tx_request,
      input  tx_msg_type,
      input  tx_number
   );
endinterface

// File: rtl/interboard_tx.sv
// Transmit stage between the game controller and the peer board.
// Latches one message per ctrl_en, then runs a 4-phase request/acknowledge
// handshake. Every waiting state is guarded by a timeout, so inter_ready
// always comes back even when the peer misbehaves.
// SYNC_STAGES must be 2 or 3.
module interboard_tx #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic            clk,
   input  logic            rst,
   interboard_tx_if.master link,
   input  logic            transmit,
   output logic            tx_active,
   output logic            tx_error,
   output logic            tx_overrun
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      REQ   = 2'd2,
      REL   = 2'd3
   } state_t;

   state_t                 state_reg, state_next;
   logic [SYNC_STAGES-1:0] ack_sync_reg;
   logic                   ack_s;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   request_reg, request_next;
   logic [2:0]             msg_type_reg;
   logic [4:0]             number_reg;
   logic                   error_reg, overrun_reg;
   logic                   accept, expired, ready;

   // Bring the asynchronous acknowledge into the clock domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_sync_reg <= '0;
      end else begin
         ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], link.rx_ack};
      end
   end

   assign ack_s = ack_sync_reg[SYNC_STAGES-1];

   // Next-state logic: handshake progress, timeout abort and message acceptance.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      expired    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (link.ctrl_en) begin
               accept     = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            // A peer still holding ack from an aborted message keeps us here.
            if (cnt_reg == CNT_LAST) begin
               expired    = 1'b1;
               state_next = IDLE;
            end else if (!ack_s) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (cnt_reg == CNT_LAST) begin
               expired    = 1'b1;
               state_next = IDLE;
            end else if (ack_s) begin
               state_next = REL;
            end
         end
         REL: begin
            if (cnt_reg == CNT_LAST) begin
               expired    = 1'b1;
               state_next = IDLE;
            end else if (!ack_s) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // The counter measures time spent in the current state only.
      if ((state_next != state_reg) || (state_reg == IDLE)) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + CNT_W'(1);
      end

      // Registered so the inter-board request pin never glitches.
      request_next = (state_next == REQ);
   end

   // State, timeout counter and request pin registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         request_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         request_reg <= request_next;
      end
   end

   // Message latch: only an accepted ctrl_en updates the data pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msg_type_reg <= 3'd0;
         number_reg   <= 5'd0;
      end else if (accept) begin
         msg_type_reg <= link.ctrl_msg_type;
         number_reg   <= link.ctrl_number;
      end
   end

   // Sticky status flags, cleared when the next message is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         error_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else if (accept) begin
         error_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         if (expired) begin
            error_reg <= 1'b1;
         end
         // Includes the completing REL cycle: the controller must wait for ready.
         if (link.ctrl_en && (state_reg != IDLE)) begin
            overrun_reg <= 1'b1;
         end
      end
   end

   // Ready is decoded from state so it drops in the cycle right after ctrl_en.
   assign ready            = (state_reg == IDLE);
   assign link.inter_ready = ready;
   assign link.tx_request  = request_reg;
   assign link.tx_msg_type = msg_type_reg;
   assign link.tx_number   = number_reg;
   assign tx_active        = transmit & ~ready;
   assign tx_error         = error_reg;
   assign tx_overrun       = overrun_reg;

endmodule
